// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder: RV32I data-memory target with wait states, valid/ready request and response channels.
// Ports: clk, rst_n (async, active-low); request channel req_valid/req_ready/req_write/req_addr/req_funct3/req_wdata;
// response channel resp_valid/resp_ready/resp_rdata/resp_err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0] f3_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0] word, load_v, wword;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [3:0] be;
  logic err, wen;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  always_comb begin
    idx = addr_q[AW+1:2];
    word = mem[idx];
    // funct3[1:0]==11 is never legal; funct3[2] is only legal for LBU/LHU
    err = ({2'b0, addr_q[31:2]} >= 32'(DEPTH_WORDS)) ||
          (f3_q[1:0] == 2'b01 && addr_q[0]) ||
          (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) ||
          (f3_q[1:0] == 2'b11) ||
          (wr_q ? f3_q[2] : f3_q[2:1] == 2'b11);
    lb = word[{addr_q[1:0], 3'b000} +: 8];
    lh = addr_q[1] ? word[31:16] : word[15:0];
    load_v = f3_q[1] ? word :
             f3_q[0] ? {{16{lh[15] & ~f3_q[2]}}, lh} : {{24{lb[7] & ~f3_q[2]}}, lb};
    be = f3_q[1] ? 4'hF : f3_q[0] ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_q[1:0];
    wword = f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    wen = state == COMMIT && wr_q && !err;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? (WAIT_CYCLES == 0 ? COMMIT : WAIT) : IDLE;
      WAIT:    state_nx = cnt == 4'(WAIT_CYCLES) ? COMMIT : WAIT;
      COMMIT:  state_nx = RESP;
      default: state_nx = resp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      f3_q <= '0;
      wdata_q <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        wr_q <= req_write;
        addr_q <= req_addr;
        f3_q <= req_funct3;
        wdata_q <= req_wdata;
        cnt <= '0;
      end
      if (state == WAIT) cnt <= cnt + 4'd1;
      if (state == COMMIT) begin
        resp_rdata <= (err || wr_q) ? 32'd0 : load_v;
        resp_err <= err;
      end
    end
  // array has no reset so contents survive rst_n
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (wen && be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
endmodule
